deit_operand_feeder: RTL and testbench

Parametrised operand-staging block between the host/DMA write side and `deit_core`. It buffers activation vectors and weight vectors in two independent FIFOs and answers the core's `ctrl_weight_load_en` / `ctrl_input_stream_en` strobes by popping one vector per cycle. Activations can optionally be skewed per row into systolic wavefront order, with zero-fill outside streaming. Sticky flags record underflow and overflow so firmware can detect starved or over-run transactions.

---
 rtl/deit_operand_feeder_if.sv | 43 ++++
 rtl/deit_operand_feeder.sv | 139 +++++++++++++
 tb/tb_deit_operand_feeder.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/deit_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// deit_operand_feeder_if : write-side, request and operand bus of the feeder
// Rev 1.0
// ============================================================================
interface deit_operand_feeder_if #(
  parameter int ARRAY_ROW  = 12,
  parameter int ARRAY_COL  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACT_DEPTH  = 64,
  parameter int WGT_DEPTH  = 16
);
  logic                             act_wr_en;
  logic [ARRAY_ROW*DATA_WIDTH-1:0]  act_wr_data;
  logic                             act_full;
  logic [$clog2(ACT_DEPTH+1)-1:0]   act_count;
  logic                             wgt_wr_en;
  logic [ARRAY_COL*DATA_WIDTH-1:0]  wgt_wr_data;
  logic                             wgt_full;
  logic [$clog2(WGT_DEPTH+1)-1:0]   wgt_count;
  logic                             ctrl_weight_load_en;
  logic                             ctrl_input_stream_en;
  logic [ARRAY_COL*DATA_WIDTH-1:0]  out_weight_vec;
  logic [ARRAY_ROW*DATA_WIDTH-1:0]  out_act_vec;
  logic                             err_clr;
  logic                             err_underflow;
  logic                             err_overflow;

  modport master (
    output act_wr_en, act_wr_data, wgt_wr_en, wgt_wr_data,
           ctrl_weight_load_en, ctrl_input_stream_en, err_clr,
    input  act_full, act_count, wgt_full, wgt_count,
           out_weight_vec, out_act_vec, err_underflow, err_overflow
  );

  modport slave (
    input  act_wr_en, act_wr_data, wgt_wr_en, wgt_wr_data,
           ctrl_weight_load_en, ctrl_input_stream_en, err_clr,
    output act_full, act_count, wgt_full, wgt_count,
           out_weight_vec, out_act_vec, err_underflow, err_overflow
  );
endinterface
`default_nettype wire

// File: rtl/deit_operand_feeder.sv
`default_nettype none
// ============================================================================
// deit_operand_feeder : activation/weight FIFOs with optional systolic skew
// Rev 1.0
// ============================================================================
module deit_operand_feeder #(
  parameter int ARRAY_ROW  = 12,
  parameter int ARRAY_COL  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ACT_DEPTH  = 64,
  parameter int WGT_DEPTH  = 16,
  parameter int SKEW_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  deit_operand_feeder_if.slave  bus
);
  localparam int AVW = ARRAY_ROW * DATA_WIDTH;
  localparam int WVW = ARRAY_COL * DATA_WIDTH;
  localparam int AAW = $clog2(ACT_DEPTH);
  localparam int ACW = $clog2(ACT_DEPTH + 1);
  localparam int WAW = $clog2(WGT_DEPTH);
  localparam int WCW = $clog2(WGT_DEPTH + 1);

  logic [AVW-1:0] r_act_mem [ACT_DEPTH];
  logic [WVW-1:0] r_wgt_mem [WGT_DEPTH];
  logic [AAW-1:0] r_act_wp, r_act_rp;
  logic [WAW-1:0] r_wgt_wp, r_wgt_rp;
  logic [ACW-1:0] r_act_cnt, w_act_cnt_nxt;
  logic [WCW-1:0] r_wgt_cnt, w_wgt_cnt_nxt;
  logic           r_act_full, r_wgt_full;
  logic [AVW-1:0] r_act_s0;
  logic [AVW-1:0] w_act_out;
  logic [WVW-1:0] r_wgt_out;
  logic           r_err_under, r_err_over;

  logic w_act_empty, w_act_pop, w_act_push;
  logic w_wgt_empty, w_wgt_pop, w_wgt_push;
  logic w_under_ev, w_over_ev;

  // A full FIFO still accepts a push when the same cycle pops it.
  assign w_act_empty = (r_act_cnt == '0);
  assign w_act_pop   = bus.ctrl_input_stream_en & ~w_act_empty;
  assign w_act_push  = bus.act_wr_en & (~r_act_full | w_act_pop);
  assign w_wgt_empty = (r_wgt_cnt == '0);
  assign w_wgt_pop   = bus.ctrl_weight_load_en & ~w_wgt_empty;
  assign w_wgt_push  = bus.wgt_wr_en & (~r_wgt_full | w_wgt_pop);

  assign w_under_ev = (bus.ctrl_input_stream_en & w_act_empty) |
                      (bus.ctrl_weight_load_en & w_wgt_empty);
  assign w_over_ev  = (bus.act_wr_en & ~w_act_push) |
                      (bus.wgt_wr_en & ~w_wgt_push);

  always_comb begin
    w_act_cnt_nxt = r_act_cnt;
    if (w_act_push && !w_act_pop)      w_act_cnt_nxt = r_act_cnt + ACW'(1);
    else if (w_act_pop && !w_act_push) w_act_cnt_nxt = r_act_cnt - ACW'(1);
    w_wgt_cnt_nxt = r_wgt_cnt;
    if (w_wgt_push && !w_wgt_pop)      w_wgt_cnt_nxt = r_wgt_cnt + WCW'(1);
    else if (w_wgt_pop && !w_wgt_push) w_wgt_cnt_nxt = r_wgt_cnt - WCW'(1);
  end

  // Storage is not reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (w_act_push) r_act_mem[r_act_wp] <= bus.act_wr_data;
    if (w_wgt_push) r_wgt_mem[r_wgt_wp] <= bus.wgt_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act_wp    <= '0;
      r_act_rp    <= '0;
      r_act_cnt   <= '0;
      r_act_full  <= 1'b0;
      r_wgt_wp    <= '0;
      r_wgt_rp    <= '0;
      r_wgt_cnt   <= '0;
      r_wgt_full  <= 1'b0;
      r_act_s0    <= '0;
      r_wgt_out   <= '0;
      r_err_under <= 1'b0;
      r_err_over  <= 1'b0;
    end else begin
      if (w_act_push) r_act_wp <= r_act_wp + AAW'(1);
      if (w_act_pop)  r_act_rp <= r_act_rp + AAW'(1);
      if (w_wgt_push) r_wgt_wp <= r_wgt_wp + WAW'(1);
      if (w_wgt_pop)  r_wgt_rp <= r_wgt_rp + WAW'(1);
      r_act_cnt  <= w_act_cnt_nxt;
      r_act_full <= (w_act_cnt_nxt == ACW'(ACT_DEPTH));
      r_wgt_cnt  <= w_wgt_cnt_nxt;
      r_wgt_full <= (w_wgt_cnt_nxt == WCW'(WGT_DEPTH));
      r_act_s0   <= w_act_pop ? r_act_mem[r_act_rp] : '0;
      // Weight output holds between requests; the core latches on its own enable.
      if (bus.ctrl_weight_load_en)
        r_wgt_out <= w_wgt_pop ? r_wgt_mem[r_wgt_rp] : '0;
      r_err_under <= w_under_ev | (r_err_under & ~bus.err_clr);
      r_err_over  <= w_over_ev  | (r_err_over  & ~bus.err_clr);
    end
  end

  generate
    if (SKEW_EN != 0) begin : g_skew
      for (genvar r = 0; r < ARRAY_ROW; r++) begin : g_lane
        if (r == 0) begin : g_l0
          assign w_act_out[DATA_WIDTH-1:0] = r_act_s0[DATA_WIDTH-1:0];
        end else if (r == 1) begin : g_l1
          logic [DATA_WIDTH-1:0] r_sr;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_sr <= '0;
            else     r_sr <= r_act_s0[DATA_WIDTH +: DATA_WIDTH];
          end
          assign w_act_out[DATA_WIDTH +: DATA_WIDTH] = r_sr;
        end else begin : g_ln
          // Oldest sample sits in the top slice of the shift register.
          logic [r*DATA_WIDTH-1:0] r_sr;
          always_ff @(posedge clk or posedge rst) begin
            if (rst) r_sr <= '0;
            else     r_sr <= {r_sr[(r-1)*DATA_WIDTH-1:0],
                              r_act_s0[r*DATA_WIDTH +: DATA_WIDTH]};
          end
          assign w_act_out[r*DATA_WIDTH +: DATA_WIDTH] =
            r_sr[r*DATA_WIDTH-1 -: DATA_WIDTH];
        end
      end
    end else begin : g_noskew
      assign w_act_out = r_act_s0;
    end
  endgenerate

  assign bus.act_full       = r_act_full;
  assign bus.act_count      = r_act_cnt;
  assign bus.wgt_full       = r_wgt_full;
  assign bus.wgt_count      = r_wgt_cnt;
  assign bus.out_weight_vec = r_wgt_out;
  assign bus.out_act_vec    = w_act_out;
  assign bus.err_underflow  = r_err_under;
  assign bus.err_overflow   = r_err_over;
endmodule
`default_nettype wire

// File: tb/tb_deit_operand_feeder.sv
`default_nettype none
// Bench: queue-based model drives a per-cycle compare of a skewed and an
// unskewed feeder fed identical stimulus, plus literal spot checks.
module tb_deit_operand_feeder;
  localparam int ROW = 12, COL = 16, DW = 8, AD = 64, WD = 16;
  localparam int AVW = ROW * DW, WVW = COL * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           awe = 0, wwe = 0, wle = 0, sie = 0, eclr = 0;
  logic [AVW-1:0] adata = '0;
  logic [WVW-1:0] wdata = '0;

  deit_operand_feeder_if #(.ARRAY_ROW(ROW), .ARRAY_COL(COL), .DATA_WIDTH(DW),
                           .ACT_DEPTH(AD), .WGT_DEPTH(WD)) bus1 ();
  deit_operand_feeder_if #(.ARRAY_ROW(ROW), .ARRAY_COL(COL), .DATA_WIDTH(DW),
                           .ACT_DEPTH(AD), .WGT_DEPTH(WD)) bus0 ();

  assign bus1.act_wr_en = awe;  assign bus0.act_wr_en = awe;
  assign bus1.act_wr_data = adata;  assign bus0.act_wr_data = adata;
  assign bus1.wgt_wr_en = wwe;  assign bus0.wgt_wr_en = wwe;
  assign bus1.wgt_wr_data = wdata;  assign bus0.wgt_wr_data = wdata;
  assign bus1.ctrl_weight_load_en = wle;  assign bus0.ctrl_weight_load_en = wle;
  assign bus1.ctrl_input_stream_en = sie;  assign bus0.ctrl_input_stream_en = sie;
  assign bus1.err_clr = eclr;  assign bus0.err_clr = eclr;

  deit_operand_feeder #(.ARRAY_ROW(ROW), .ARRAY_COL(COL), .DATA_WIDTH(DW),
    .ACT_DEPTH(AD), .WGT_DEPTH(WD), .SKEW_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  deit_operand_feeder #(.ARRAY_ROW(ROW), .ARRAY_COL(COL), .DATA_WIDTH(DW),
    .ACT_DEPTH(AD), .WGT_DEPTH(WD), .SKEW_EN(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [AVW-1:0] avec(input int k);
    logic [AVW-1:0] v;
    for (int r = 0; r < ROW; r++) v[r*DW +: DW] = 8'(k + r);
    return v;
  endfunction

  function automatic logic [WVW-1:0] wvec_fill(input int base);
    logic [WVW-1:0] v;
    for (int c = 0; c < COL; c++) v[c*DW +: DW] = 8'(base + c);
    return v;
  endfunction

  // ---------------- model ----------------
  logic [AVW-1:0] m_aq [$];
  logic [WVW-1:0] m_wq [$];
  logic [AVW-1:0] m_hist [ROW];   // m_hist[d] = stage-0 vector popped d edges ago
  logic [WVW-1:0] m_wout = '0;
  logic           m_under = 0, m_over = 0;

  task automatic model_reset();
    m_aq.delete();
    m_wq.delete();
    for (int d = 0; d < ROW; d++) m_hist[d] = '0;
    m_wout = '0; m_under = 0; m_over = 0;
  endtask

  task automatic model_step();
    bit a_emp, w_emp, a_pop, w_pop, a_push, w_push, ev_u, ev_o;
    logic [AVW-1:0] s0;
    a_emp  = (m_aq.size() == 0);
    w_emp  = (m_wq.size() == 0);
    a_pop  = sie && !a_emp;
    w_pop  = wle && !w_emp;
    a_push = awe && (m_aq.size() < AD || a_pop);
    w_push = wwe && (m_wq.size() < WD || w_pop);
    ev_u   = (sie && a_emp) || (wle && w_emp);
    ev_o   = (awe && !a_push) || (wwe && !w_push);
    s0 = a_pop ? m_aq.pop_front() : '0;
    if (wle) m_wout = w_pop ? m_wq.pop_front() : '0;
    if (a_push) m_aq.push_back(adata);
    if (w_push) m_wq.push_back(wdata);
    for (int d = ROW - 1; d > 0; d--) m_hist[d] = m_hist[d-1];
    m_hist[0] = s0;
    m_under = ev_u || (m_under && !eclr);
    m_over  = ev_o || (m_over && !eclr);
  endtask

  function automatic logic [AVW-1:0] exp_skew();
    logic [AVW-1:0] v;
    for (int r = 0; r < ROW; r++) v[r*DW +: DW] = m_hist[r][r*DW +: DW];
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("act_count", 128'(bus1.act_count), 128'(m_aq.size()));
      chk("act_full",  128'(bus1.act_full),  128'(m_aq.size() == AD));
      chk("wgt_count", 128'(bus1.wgt_count), 128'(m_wq.size()));
      chk("wgt_full",  128'(bus1.wgt_full),  128'(m_wq.size() == WD));
      chk("out_weight_vec", 128'(bus1.out_weight_vec), 128'(m_wout));
      chk("out_act_vec_skew", 128'(bus1.out_act_vec), 128'(exp_skew()));
      chk("err_underflow", 128'(bus1.err_underflow), 128'(m_under));
      chk("err_overflow",  128'(bus1.err_overflow),  128'(m_over));
      chk("out_act_vec_noskew", 128'(bus0.out_act_vec), 128'(m_hist[0]));
      chk("out_weight_vec_noskew", 128'(bus0.out_weight_vec), 128'(m_wout));
      chk("act_count_noskew", 128'(bus0.act_count), 128'(m_aq.size()));
      chk("flags_noskew", 128'({bus0.err_underflow, bus0.err_overflow}),
          128'({m_under, m_over}));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    rst = 0;
    step();

    // Skewed streaming of 16 vectors
    awe = 1;
    for (int k = 0; k < 16; k++) begin adata = avec(k); step(); end
    awe = 0;
    chk("lit_act_count_16", 128'(bus1.act_count), 128'd16);
    sie = 1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (k == 3) begin
        chk("lit_skew_lane0", 128'(bus1.out_act_vec[0 +: DW]), 128'd3);
        chk("lit_skew_lane3", 128'(bus1.out_act_vec[3*DW +: DW]), 128'd3);
        chk("lit_skew_lane4", 128'(bus1.out_act_vec[4*DW +: DW]), 128'd0);
        chk("lit_noskew_lane11", 128'(bus0.out_act_vec[11*DW +: DW]), 128'd14);
      end
    end
    sie = 0;
    repeat (ROW) step();
    chk("lit_act_count_0", 128'(bus1.act_count), 128'd0);
    chk("lit_flags_clean", 128'({bus1.err_underflow, bus1.err_overflow}), 128'd0);
    chk("lit_drained_zero", 128'(bus1.out_act_vec), 128'd0);

    // Weight fill, overflow, push-with-pop when full
    wwe = 1; wdata = wvec_fill(1);
    repeat (WD) step();
    wdata = {WVW/8{8'hAA}};
    step();
    wwe = 0;
    chk("lit_wgt_full", 128'(bus1.wgt_full), 128'd1);
    chk("lit_wgt_count_16", 128'(bus1.wgt_count), 128'd16);
    chk("lit_err_overflow", 128'(bus1.err_overflow), 128'd1);
    eclr = 1; step(); eclr = 0;
    chk("lit_overflow_clr", 128'(bus1.err_overflow), 128'd0);
    wwe = 1; wle = 1; wdata = {WVW/8{8'hBB}};
    step();
    wwe = 0; wle = 0;
    chk("lit_wgt_count_keep", 128'(bus1.wgt_count), 128'd16);
    chk("lit_wgt_popped", 128'(bus1.out_weight_vec), 128'(wvec_fill(1)));
    chk("lit_no_overflow", 128'(bus1.err_overflow), 128'd0);
    wle = 1;
    repeat (WD) step();
    wle = 0;
    chk("lit_last_wgt_bb", 128'(bus1.out_weight_vec), 128'({WVW/8{8'hBB}}));
    step();
    chk("lit_wgt_hold", 128'(bus1.out_weight_vec), 128'({WVW/8{8'hBB}}));

    // Underflow on empty activation FIFO
    sie = 1;
    repeat (3) step();
    sie = 0;
    chk("lit_err_underflow", 128'(bus1.err_underflow), 128'd1);
    chk("lit_underflow_count", 128'(bus1.act_count), 128'd0);
    chk("lit_underflow_zero", 128'(bus0.out_act_vec), 128'd0);
    eclr = 1; step(); eclr = 0;
    chk("lit_underflow_clr", 128'(bus1.err_underflow), 128'd0);

    // Pointer wrap: 3 x depth interleaved push/pop
    awe = 1; adata = avec(100); step();
    sie = 1;
    for (int k = 1; k <= 3 * AD; k++) begin adata = avec(100 + k); step(); end
    awe = 0;
    step();
    sie = 0;
    repeat (ROW) step();
    chk("lit_wrap_flags", 128'({bus1.err_underflow, bus1.err_overflow}), 128'd0);
    chk("lit_wrap_count", 128'(bus1.act_count), 128'd0);

    // Reset mid-stream
    awe = 1;
    for (int k = 0; k < 16; k++) begin adata = avec(40 + k); step(); end
    awe = 0;
    wwe = 1; wdata = wvec_fill(7); step(); wwe = 0;
    wle = 1; step(); wle = 0;
    sie = 1;
    repeat (8) step();
    #1 rst = 1;
    #1;
    chk("lit_rst_act", 128'(bus1.out_act_vec), 128'd0);
    chk("lit_rst_wgt", 128'(bus1.out_weight_vec), 128'd0);
    chk("lit_rst_count", 128'(bus1.act_count), 128'd0);
    sie = 0;
    step(); step();
    rst = 0;
    step();
    awe = 1;
    for (int k = 0; k < 4; k++) begin adata = avec(200 + k); step(); end
    awe = 0;
    sie = 1;
    repeat (4) step();
    sie = 0;
    repeat (ROW) step();
    chk("lit_post_rst_flags", 128'({bus1.err_underflow, bus1.err_overflow}), 128'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
